// File: rtl/input_conditioner.sv
// input_conditioner: per-channel resynchroniser, glitch filter and edge strobes
// for slow asynchronous level inputs.
// Optional feature macro: IN_COND_GLITCH_EN adds sticky per-channel glitch flags
// cleared by glitch_clr; without it glitch is tied low and glitch_clr is unused.
module input_conditioner #(
  parameter int             N         = 4,
  parameter int             STAGES    = 2,
  parameter int             FILTER    = 4,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [N-1:0] bypass,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  input  logic         glitch_clr,
  output logic [N-1:0] glitch
);

  // Counter only needs to reach FILTER-1 before the candidate is accepted.
  localparam int              CW       = $clog2(FILTER + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER - 1);

`ifndef IN_COND_GLITCH_EN
  logic unused_glitch_clr;
  assign unused_glitch_clr = glitch_clr;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_chan
      logic [STAGES-1:0] sync_reg;
      logic [CW-1:0]     cnt_reg;
      logic              q_reg;
      logic              q_d_reg;
      logic              s;

      assign s = sync_reg[STAGES-1];

      // Resynchroniser: shift the raw pad level through STAGES flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_reg <= {STAGES{RESET_VAL[gi]}};
        else     sync_reg <= {sync_reg[STAGES-2:0], in[gi]};
      end

      // Glitch filter: accept a new level only after FILTER consecutive differing cycles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg   <= RESET_VAL[gi];
          cnt_reg <= '0;
        end else if (bypass[gi]) begin
          q_reg   <= s;
          cnt_reg <= '0;
        end else if (s == q_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          q_reg   <= s;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      // Previous q, so strobes appear in the same cycle q shows its new value.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q_d_reg <= RESET_VAL[gi];
        else     q_d_reg <= q_reg;
      end

      assign q[gi]    = q_reg;
      assign rise[gi] = q_reg & ~q_d_reg;
      assign fall[gi] = ~q_reg & q_d_reg;

`ifdef IN_COND_GLITCH_EN
      logic glitch_reg;

      // Sticky flag on a rejected candidate; a new rejection beats a clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            glitch_reg <= 1'b0;
        else if (!bypass[gi] && (s == q_reg) && (cnt_reg != '0)) glitch_reg <= 1'b1;
        else if (glitch_clr)                                glitch_reg <= 1'b0;
      end

      assign glitch[gi] = glitch_reg;
`else
      assign glitch[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (N=4, STAGES=2, FILTER=4, RESET_VAL=1010).
module tb_input_conditioner;
  localparam int           N         = 4;
  localparam int           STAGES    = 2;
  localparam int           FILTER    = 4;
  localparam logic [N-1:0] RESET_VAL = 4'b1010;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] din = RESET_VAL;
  logic [N-1:0] bypass = '0;
  logic         glitch_clr = 1'b0;
  logic [N-1:0] q, rise, fall, glitch;

  int checks = 0;
  int errors = 0;

  // Reference model: delay line for the synchroniser, run length of disagreeing samples.
  logic [N-1:0] m_pipe [STAGES];
  logic [N-1:0] m_q, m_qd, m_glitch;
  int           m_run [N];

  input_conditioner #(.N(N), .STAGES(STAGES), .FILTER(FILTER), .RESET_VAL(RESET_VAL)) dut (
    .clk(clk), .rst(rst), .in(din), .bypass(bypass), .q(q), .rise(rise), .fall(fall),
    .glitch_clr(glitch_clr), .glitch(glitch)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_rise();
    return m_q & ~m_qd;
  endfunction

  function automatic logic [N-1:0] exp_fall();
    return ~m_q & m_qd;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) m_pipe[k] = RESET_VAL;
    m_q = RESET_VAL;
    m_qd = RESET_VAL;
    m_glitch = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] s, nq, ng;
    s  = m_pipe[STAGES-1];
    nq = m_q;
    ng = glitch_clr ? '0 : m_glitch;
    for (int i = 0; i < N; i++) begin
      if (bypass[i]) begin
        nq[i] = s[i];
        m_run[i] = 0;
      end else if (s[i] == m_q[i]) begin
        if (m_run[i] > 0) ng[i] = 1'b1;
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] >= FILTER) begin
          nq[i] = s[i];
          m_run[i] = 0;
        end
      end
    end
`ifndef IN_COND_GLITCH_EN
    ng = '0;
`endif
    m_qd = m_q;
    m_q = nq;
    m_glitch = ng;
    for (int k = STAGES - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = din;
  endtask

  // One clock: model follows the edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    din = RESET_VAL; bypass = '0; glitch_clr = 1'b0;
    @(posedge clk); #1;
    apply_reset();
    checks++; if (q !== RESET_VAL) begin errors++; $display("FAIL reset_q got %b want %b", q, RESET_VAL); end
    checks++; if ((rise | fall) !== '0) begin errors++; $display("FAIL reset_strobe got rise %b fall %b want 0", rise, fall); end
    checks++; if (glitch !== '0) begin errors++; $display("FAIL reset_glitch got %b want 0", glitch); end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ((rise | fall) !== '0) begin errors++; $display("FAIL reset_release_strobe cyc %0d got rise %b fall %b want 0", c, rise, fall); end
    end
    $display("test_reset: q=%b", q);
  endtask

  task automatic test_step();
    din = RESET_VAL | 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (q[0] !== (c >= 6)) begin errors++; $display("FAIL step_q0 cyc %0d got %b want %b", c, q[0], c >= 6); end
      checks++; if (rise[0] !== (c == 6)) begin errors++; $display("FAIL step_rise0 cyc %0d got %b want %b", c, rise[0], c == 6); end
      checks++; if ({q, rise, fall} !== {m_q, exp_rise(), exp_fall()}) begin
        errors++; $display("FAIL step_model cyc %0d got q%b r%b f%b want q%b r%b f%b", c, q, rise, fall, m_q, exp_rise(), exp_fall());
      end
    end
    $display("test_step: q=%b", q);
  endtask

  task automatic test_glitch_pulse();
    din[1] = 1'b0;
    repeat (8) tick();
    checks++; if (q[1] !== 1'b0) begin errors++; $display("FAIL glitch_pre_q1 got %b want 0", q[1]); end
    for (int c = 0; c < 14; c++) begin
      din[1] = (c < 3);
      tick();
      checks++; if (q[1] !== 1'b0 || rise[1] !== 1'b0) begin errors++; $display("FAIL pulse_q1 cyc %0d got q %b rise %b want 0 0", c, q[1], rise[1]); end
      checks++; if (glitch !== m_glitch) begin errors++; $display("FAIL pulse_glitch cyc %0d got %b want %b", c, glitch, m_glitch); end
    end
`ifdef IN_COND_GLITCH_EN
    checks++; if (glitch[1] !== 1'b1) begin errors++; $display("FAIL pulse_glitch1_set got %b want 1", glitch[1]); end
`endif
    glitch_clr = 1'b1;
    tick();
    glitch_clr = 1'b0;
    checks++; if (glitch !== '0) begin errors++; $display("FAIL glitch_clear got %b want 0", glitch); end
    $display("test_glitch_pulse: glitch=%b", glitch);
  endtask

  task automatic test_bypass();
    logic [N-1:0] hist [$];
    int edges = 0, strobes = 0;
    bypass = 4'b0100;
    for (int c = 0; c < 32; c++) begin
      if (c % 4 == 0 && c < 24) begin din[2] = ~din[2]; edges++; end
      hist.push_back(din);
      tick();
      if (rise[2] | fall[2]) strobes++;
      if (hist.size() >= 3) begin
        checks++; if (q[2] !== hist[hist.size()-3][2]) begin errors++; $display("FAIL bypass_lag cyc %0d got %b want %b", c, q[2], hist[hist.size()-3][2]); end
      end
      checks++; if ({q, rise, fall} !== {m_q, exp_rise(), exp_fall()}) begin
        errors++; $display("FAIL bypass_model cyc %0d got q%b r%b f%b want q%b r%b f%b", c, q, rise, fall, m_q, exp_rise(), exp_fall());
      end
    end
    checks++; if (strobes !== edges) begin errors++; $display("FAIL bypass_strobes got %0d want %0d", strobes, edges); end
    bypass = '0;
    $display("test_bypass: edges=%0d strobes=%0d", edges, strobes);
  endtask

  task automatic test_reset_value();
    din = '0;
    repeat (8) tick();
    apply_reset();
    tick();
    rst = 1'b0;
    checks++; if (q !== RESET_VAL) begin errors++; $display("FAIL resetval_q got %b want %b", q, RESET_VAL); end
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++; if (fall !== ((c == 6) ? RESET_VAL : 4'b0000)) begin errors++; $display("FAIL resetval_fall cyc %0d got %b want %b", c, fall, (c == 6) ? RESET_VAL : 4'b0000); end
    end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL resetval_final got %b want 0000", q); end
    $display("test_reset_value: q=%b", q);
  endtask

  task automatic test_reset_midcount();
    din = 4'b0001;
    repeat (5) tick();
    checks++; if (q[0] !== 1'b0) begin errors++; $display("FAIL midcount_pre got %b want 0", q[0]); end
    apply_reset();
    checks++; if (q[0] !== RESET_VAL[0] || (rise | fall) !== '0) begin errors++; $display("FAIL midcount_reset got q0 %b r %b f %b want %b 0 0", q[0], rise, fall, RESET_VAL[0]); end
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++; if (q[0] !== (c >= 6) || rise[0] !== (c == 6)) begin errors++; $display("FAIL midcount_q0 cyc %0d got q %b rise %b want %b %b", c, q[0], rise[0], c >= 6, c == 6); end
    end
    $display("test_reset_midcount: q=%b", q);
  endtask

  task automatic test_back_to_back();
    din = '0;
    repeat (8) tick();
    glitch_clr = 1'b1;
    din = 4'b1111;
    tick();
    din = 4'b0000;
    repeat (3) tick();
    glitch_clr = 1'b0;
`ifdef IN_COND_GLITCH_EN
    checks++; if (glitch !== 4'b1111) begin errors++; $display("FAIL setclr_glitch got %b want 1111", glitch); end
`else
    checks++; if (glitch !== 4'b0000) begin errors++; $display("FAIL setclr_glitch got %b want 0000", glitch); end
`endif
    din = 4'b1111;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++; if (rise !== ((c == 6) ? 4'b1111 : 4'b0000)) begin errors++; $display("FAIL all_rise cyc %0d got %b want %b", c, rise, (c == 6) ? 4'b1111 : 4'b0000); end
    end
    checks++; if (glitch !== m_glitch) begin errors++; $display("FAIL all_glitch_hold got %b want %b", glitch, m_glitch); end
    $display("test_back_to_back: rise seen, glitch=%b", glitch);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) din[i] = ~din[i];
      if ($urandom_range(99) == 0) bypass = N'($urandom);
      glitch_clr = ($urandom_range(19) == 0);
      if ($urandom_range(299) == 0) apply_reset();
      tick();
      rst = 1'b0;
      checks++; if ({q, rise, fall, glitch} !== {m_q, exp_rise(), exp_fall(), m_glitch}) begin
        errors++; bad++;
        $display("FAIL random cyc %0d got q%b r%b f%b g%b want q%b r%b f%b g%b", c, q, rise, fall, glitch, m_q, exp_rise(), exp_fall(), m_glitch);
      end
    end
    glitch_clr = 1'b0;
    bypass = '0;
    $display("test_random: 1500 cycles, %0d bad", bad);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_glitch_pulse();
    test_bypass();
    test_reset_value();
    test_reset_midcount();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
